// File: rtl/pcie_ss_pkg.sv
// Shared types and widths for the PCIe SS TX/RX streaming blocks.
package pcie_ss_pkg;

  localparam int TDATA_WIDTH = 64;
  localparam int TUSER_WIDTH = 8;
  localparam int PCIE_SS_TX_ARB_MAX_PORTS = 16;

  typedef enum logic {
    ARB_IDLE,
    ARB_LOCKED
  } arb_state_e;

endpackage

// File: rtl/pcie_ss_axis_skid.sv
// Two-entry AXI-S register slice: fully registered outputs and a registered ready,
// full throughput when the sink is always ready.
module pcie_ss_axis_skid #(
  parameter int TDATA_W = 64,
  parameter int TUSER_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  input  logic [TDATA_W-1:0]   s_tdata,
  input  logic [TDATA_W/8-1:0] s_tkeep,
  input  logic [TUSER_W-1:0]   s_tuser,
  input  logic                 s_tlast,
  output logic                 m_tvalid,
  input  logic                 m_tready,
  output logic [TDATA_W-1:0]   m_tdata,
  output logic [TDATA_W/8-1:0] m_tkeep,
  output logic [TUSER_W-1:0]   m_tuser,
  output logic                 m_tlast
);

  localparam int PW = TDATA_W + TDATA_W/8 + TUSER_W + 1;

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [PW-1:0] in_bus;
  logic          head_vld;
  logic          tail_vld;
  logic          push;
  logic          pop;

  assign in_bus   = {s_tdata, s_tkeep, s_tuser, s_tlast};
  // tail is only ever occupied behind a valid head, so it alone marks "full"
  assign s_tready = ~tail_vld;
  assign push     = s_tvalid & ~tail_vld;
  assign pop      = head_vld & m_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q   <= '0;
      tail_q   <= '0;
      head_vld <= 1'b0;
      tail_vld <= 1'b0;
    end else if (pop) begin
      if (tail_vld) begin
        head_q   <= tail_q;
        tail_vld <= 1'b0;
      end else if (push) begin
        head_q <= in_bus;
      end else begin
        head_vld <= 1'b0;
      end
    end else if (push) begin
      if (!head_vld) begin
        head_q   <= in_bus;
        head_vld <= 1'b1;
      end else begin
        tail_q   <= in_bus;
        tail_vld <= 1'b1;
      end
    end
  end

  assign m_tvalid = head_vld;
  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = head_q;

endmodule

// File: rtl/pcie_ss_tx_arb.sv
// Packet-atomic round-robin arbiter onto the single PCIe SS TX stream.
// Optional per-port packet counters: define PCIE_SS_TX_ARB_STATS_EN.
//   state      | meaning
//   ARB_IDLE   | no grant held; pick next requester from rr_ptr (1-cycle bubble)
//   ARB_LOCKED | grant_port owns the stream until its tlast beat transfers
module pcie_ss_tx_arb
  import pcie_ss_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int TDATA_W   = TDATA_WIDTH,
  parameter int TUSER_W   = TUSER_WIDTH,
  localparam int GW       = $clog2(NUM_PORTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_PORTS-1:0]           s_tvalid,
  output logic [NUM_PORTS-1:0]           s_tready,
  input  logic [NUM_PORTS*TDATA_W-1:0]   s_tdata,
  input  logic [NUM_PORTS*TDATA_W/8-1:0] s_tkeep,
  input  logic [NUM_PORTS*TUSER_W-1:0]   s_tuser,
  input  logic [NUM_PORTS-1:0]           s_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [TDATA_W-1:0]             m_tdata,
  output logic [TDATA_W/8-1:0]           m_tkeep,
  output logic [TUSER_W-1:0]             m_tuser,
  output logic                           m_tlast,
  output logic [GW-1:0]                  grant_port,
  output logic                           busy
`ifdef PCIE_SS_TX_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]        stat_pkt_cnt
`endif
);

  localparam int KW = TDATA_W/8;
  localparam logic [GW:0]   NP_W = (GW+1)'(NUM_PORTS);
  localparam logic [GW-1:0] LAST = GW'(NUM_PORTS-1);

  arb_state_e        state;
  logic [GW-1:0]     rr_ptr;
  logic              skid_in_ready;
  logic              sel_tvalid;
  logic [TDATA_W-1:0] sel_tdata;
  logic [KW-1:0]     sel_tkeep;
  logic [TUSER_W-1:0] sel_tuser;
  logic              sel_tlast;
  logic              pkt_end;

  // Rotate requests so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  function automatic logic [GW-1:0] rr_pick(input logic [NUM_PORTS-1:0] req,
                                            input logic [GW-1:0]        ptr);
    logic [2*NUM_PORTS-1:0] dbl;
    logic [NUM_PORTS-1:0]   rot;
    logic [GW-1:0]          idx;
    logic [GW:0]            sum;
    dbl = {req, req} >> ptr;
    rot = dbl[NUM_PORTS-1:0];
    idx = '0;
    for (int i = NUM_PORTS-1; i >= 0; i--) begin
      if (rot[i]) idx = GW'(i);
    end
    sum = {1'b0, ptr} + {1'b0, idx};
    if (sum >= NP_W) sum = sum - NP_W;
    return sum[GW-1:0];
  endfunction

  always_comb begin
    sel_tvalid = busy & s_tvalid[grant_port];
    sel_tdata  = s_tdata[grant_port*TDATA_W +: TDATA_W];
    sel_tkeep  = s_tkeep[grant_port*KW +: KW];
    sel_tuser  = s_tuser[grant_port*TUSER_W +: TUSER_W];
    sel_tlast  = s_tlast[grant_port];
    s_tready   = '0;
    if (busy) s_tready[grant_port] = skid_in_ready;
  end

  assign pkt_end = sel_tvalid & skid_in_ready & sel_tlast;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ARB_IDLE;
      rr_ptr     <= '0;
      grant_port <= '0;
      busy       <= 1'b0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (|s_tvalid) begin
            grant_port <= rr_pick(s_tvalid, rr_ptr);
            state      <= ARB_LOCKED;
            busy       <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          // pointer moves only when the packet closes, never on the grant
          if (pkt_end) begin
            state  <= ARB_IDLE;
            busy   <= 1'b0;
            rr_ptr <= (grant_port == LAST) ? '0 : grant_port + 1'b1;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef PCIE_SS_TX_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_pkt_cnt <= '0;
    end else if (pkt_end) begin
      stat_pkt_cnt[grant_port*32 +: 32] <= stat_pkt_cnt[grant_port*32 +: 32] + 32'd1;
    end
  end
`endif

  pcie_ss_axis_skid #(
    .TDATA_W (TDATA_W),
    .TUSER_W (TUSER_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (sel_tvalid),
    .s_tready (skid_in_ready),
    .s_tdata  (sel_tdata),
    .s_tkeep  (sel_tkeep),
    .s_tuser  (sel_tuser),
    .s_tlast  (sel_tlast),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast)
  );

endmodule

// File: tb/tb_pcie_ss_tx_arb.sv
// Bench for pcie_ss_tx_arb: per-port packet sources, a cycle model of the arbiter
// and skid occupancy, and a scoreboard of accepted beats checked at the output.
module tb_pcie_ss_tx_arb;
  import pcie_ss_pkg::*;

  localparam int NP = 4;
  localparam int DW = TDATA_WIDTH;
  localparam int KW = DW/8;
  localparam int UW = TUSER_WIDTH;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [NP-1:0]    s_tvalid, s_tready, s_tlast;
  logic [NP*DW-1:0] s_tdata;
  logic [NP*KW-1:0] s_tkeep;
  logic [NP*UW-1:0] s_tuser;
  logic            m_tvalid, m_tready, m_tlast;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic [UW-1:0]    m_tuser;
  logic [1:0]       grant_port;
  logic            busy;
`ifdef PCIE_SS_TX_ARB_STATS_EN
  logic [NP*32-1:0] stat_pkt_cnt;
`endif

  always #5 clk = ~clk;

  pcie_ss_tx_arb #(.NUM_PORTS(NP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .s_tvalid   (s_tvalid),
    .s_tready   (s_tready),
    .s_tdata    (s_tdata),
    .s_tkeep    (s_tkeep),
    .s_tuser    (s_tuser),
    .s_tlast    (s_tlast),
    .m_tvalid   (m_tvalid),
    .m_tready   (m_tready),
    .m_tdata    (m_tdata),
    .m_tkeep    (m_tkeep),
    .m_tuser    (m_tuser),
    .m_tlast    (m_tlast),
    .grant_port (grant_port),
    .busy       (busy)
`ifdef PCIE_SS_TX_ARB_STATS_EN
    ,
    .stat_pkt_cnt (stat_pkt_cnt)
`endif
  );

  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic [UW-1:0] u;
    logic          l;
    logic [1:0]    p;
  } beat_t;

  beat_t sb[$];
  int    out_order[$];
  int    pop_cyc[$];

  int n_chk, n_bad, cyc, n_out;
  int pkts_left[NP], plen[NP], beat_i[NP], pkt_no[NP], stall_beat[NP], stall_rem[NP];
  bit mlock;
  int mg, mrr, mcnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic beat_t mk_beat(input int p);
    beat_t b;
    logic  l;
    l   = (beat_i[p] == plen[p] - 1);
    b.d = {8'(p), 16'(pkt_no[p]), 16'(beat_i[p]), 24'hC35A96};
    b.k = l ? KW'(8'h0F) : '1;
    b.u = UW'(p*16 + beat_i[p]);
    b.l = l;
    b.p = 2'(p);
    return b;
  endfunction

  function automatic bit stalled(input int p);
    return (stall_rem[p] > 0) && (beat_i[p] == stall_beat[p]);
  endfunction

  function automatic bit all_done();
    for (int p = 0; p < NP; p++) if (pkts_left[p] != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drive_inputs();
    beat_t b;
    for (int p = 0; p < NP; p++) begin
      b = mk_beat(p);
      s_tvalid[p]           = (pkts_left[p] > 0) && !stalled(p);
      s_tdata[p*DW +: DW]   = b.d;
      s_tkeep[p*KW +: KW]   = b.k;
      s_tuser[p*UW +: UW]   = b.u;
      s_tlast[p]            = b.l;
    end
  endtask

  task automatic start_port(input int p, input int npk, input int len, input int sb_at, input int st);
    pkts_left[p]  = npk;
    plen[p]       = len;
    beat_i[p]     = 0;
    stall_beat[p] = sb_at;
    stall_rem[p]  = st;
  endtask

  // One clock: check DUT against the model at negedge, advance model, drive next inputs.
  task automatic cycle();
    logic [NP-1:0] exp_rdy, st;
    beat_t e, b;
    bit    acc, popm;
    int    g;
    @(negedge clk);
    exp_rdy = '0;
    if (mlock && mcnt < 2) exp_rdy[mg] = 1'b1;
    chk("s_tready", 64'(s_tready), 64'(exp_rdy));
    chk("m_tvalid", 64'(m_tvalid), 64'(mcnt > 0));
    chk("busy", 64'(busy), 64'(mlock));
    if (mlock) chk("grant_port", 64'(grant_port), 64'(mg));
    for (int p = 0; p < NP; p++) st[p] = stalled(p);
    popm = (mcnt > 0) && m_tready;
    if (m_tvalid) begin
      if (sb.size() == 0) begin
        chk("spurious_beat", 64'(m_tvalid), 64'(0));
      end else begin
        e = sb[0];
        chk("m_tdata", 64'(m_tdata), 64'(e.d));
        chk("m_tkeep", 64'(m_tkeep), 64'(e.k));
        chk("m_tuser", 64'(m_tuser), 64'(e.u));
        chk("m_tlast", 64'(m_tlast), 64'(e.l));
        if (m_tready) begin
          void'(sb.pop_front());
          n_out++;
          pop_cyc.push_back(cyc);
          if (e.l) out_order.push_back(int'(e.p));
        end
      end
    end
    acc = 1'b0;
    if (!mlock) begin
      if (|s_tvalid) begin
        g = mrr;
        for (int i = NP-1; i >= 0; i--) if (s_tvalid[(mrr+i)%NP]) g = (mrr+i)%NP;
        mg    = g;
        mlock = 1'b1;
      end
    end else if (mcnt < 2 && s_tvalid[mg]) begin
      acc = 1'b1;
      b   = mk_beat(mg);
      sb.push_back(b);
      if (b.l) begin
        beat_i[mg] = 0;
        pkt_no[mg]++;
        pkts_left[mg]--;
        mlock = 1'b0;
        mrr   = (mg + 1) % NP;
      end else begin
        beat_i[mg]++;
      end
    end
    for (int p = 0; p < NP; p++) if (st[p]) stall_rem[p]--;
    mcnt = mcnt + int'(acc) - int'(popm);
    cyc++;
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      pkts_left[p] = 0; beat_i[p] = 0; plen[p] = 1;
      stall_beat[p] = 0; stall_rem[p] = 0;
      pkt_no[p] += 1;
    end
    sb.delete(); out_order.delete(); pop_cyc.delete();
    mlock = 1'b0; mg = 0; mrr = 0; mcnt = 0; n_out = 0;
    m_tready = 1'b1;
    drive_inputs();
    @(negedge clk);
    chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
    chk("rst_s_tready", 64'(s_tready), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_grant", 64'(grant_port), 64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic run_until_done(input int max_cyc, input bit rnd);
    int n;
    bit done;
    n = 0;
    drive_inputs();
    done = all_done() && mcnt == 0 && !mlock && sb.size() == 0;
    while (!done && n < max_cyc) begin
      if (rnd) m_tready = 1'($urandom_range(0, 1));
      cycle();
      n++;
      done = all_done() && mcnt == 0 && !mlock && sb.size() == 0;
    end
    chk("drain_done", 64'(done), 64'(1));
    m_tready = 1'b1;
    repeat (2) cycle();
  endtask

  initial begin
    int c0;
    n_chk = 0; n_bad = 0; cyc = 0;
    for (int p = 0; p < NP; p++) pkt_no[p] = 0;
    s_tvalid = '0; s_tdata = '0; s_tkeep = '0; s_tuser = '0; s_tlast = '0;
    do_reset();

    // fairness: every port holds two 2-beat packets
    for (int p = 0; p < NP; p++) start_port(p, 2, 2, 0, 0);
    c0 = cyc;
    run_until_done(200, 1'b0);
    chk("fair_npkts", 64'(out_order.size()), 64'(8));
    if (out_order.size() == 8)
      for (int i = 0; i < 8; i++) chk("fair_order", 64'(out_order[i]), 64'(i % NP));
    if (pop_cyc.size() > 0) chk("fair_cycles", 64'(pop_cyc[pop_cyc.size()-1] - c0), 64'(24));

    // reset in the middle of traffic, then first grant goes to port 0
    for (int p = 0; p < NP; p++) start_port(p, 3, 2, 0, 0);
    drive_inputs();
    repeat (5) cycle();
    do_reset();
    for (int p = 0; p < NP; p++) start_port(p, 1, 2, 0, 0);
    run_until_done(100, 1'b0);
    if (out_order.size() > 0) chk("post_rst_first", 64'(out_order[0]), 64'(0));
    chk("post_rst_npkts", 64'(out_order.size()), 64'(4));

    // lock: port 1 stalls mid-packet, port 2 must wait
    do_reset();
    start_port(1, 1, 4, 2, 5);
    start_port(2, 1, 2, 0, 0);
    run_until_done(100, 1'b0);
    chk("lock_npkts", 64'(out_order.size()), 64'(2));
    if (out_order.size() == 2) begin
      chk("lock_first", 64'(out_order[0]), 64'(1));
      chk("lock_second", 64'(out_order[1]), 64'(2));
    end

    // backpressure during an 8-beat packet
    do_reset();
    start_port(0, 1, 8, 0, 0);
    drive_inputs();
    repeat (3) cycle();
    m_tready = 1'b0;
    repeat (10) cycle();
    chk("bp_s_tready", 64'(s_tready[0]), 64'(0));
    chk("bp_m_tvalid", 64'(m_tvalid), 64'(1));
    m_tready = 1'b1;
    run_until_done(100, 1'b0);
    chk("bp_beats", 64'(n_out), 64'(8));

    // single-beat packets from port 3 only
    do_reset();
    start_port(3, 4, 1, 0, 0);
    run_until_done(100, 1'b0);
    chk("single_beats", 64'(n_out), 64'(4));
    if (pop_cyc.size() == 4)
      for (int i = 1; i < 4; i++) chk("single_gap", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'(2));

    // mixed random lengths, stalls and sink backpressure
    do_reset();
    for (int p = 0; p < NP; p++) begin
      int len;
      len = int'($urandom_range(1, 5));
      start_port(p, 3, len, int'($urandom_range(0, len-1)), int'($urandom_range(0, 3)));
    end
    run_until_done(3000, 1'b1);
    chk("rand_npkts", 64'(out_order.size()), 64'(12));

`ifdef PCIE_SS_TX_ARB_STATS_EN
    do_reset();
    start_port(0, 5, 2, 0, 0);
    start_port(2, 7, 1, 0, 0);
    run_until_done(300, 1'b0);
    chk("stat_p0", 64'(stat_pkt_cnt[0*32 +: 32]), 64'(5));
    chk("stat_p1", 64'(stat_pkt_cnt[1*32 +: 32]), 64'(0));
    chk("stat_p2", 64'(stat_pkt_cnt[2*32 +: 32]), 64'(7));
    chk("stat_p3", 64'(stat_pkt_cnt[3*32 +: 32]), 64'(0));
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
